// File: rtl/spi_rx_sync_if.sv
// SPI pins plus the receive-FIFO read port of spi_rx_sync.
// slave = the receiver side, master = the SPI sender / byte consumer side.
interface spi_rx_sync_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          sclk;
   logic          cs;
   logic          mosi;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [LW-1:0] rx_level;

   modport slave (
      input  sclk, cs, mosi, rx_ready,
      output rx_data, rx_valid, rx_level
   );

   modport master (
      output sclk, cs, mosi, rx_ready,
      input  rx_data, rx_valid, rx_level
   );
endinterface

// File: rtl/spi_rx_sync.sv
// SPI slave receiver in the clk domain: synchronized pins, byte assembly, FWFT receive FIFO.
// Optional macro SPI_RX_OVF_CNT_EN adds ovf_count, a saturating count of dropped bytes.
module spi_rx_sync #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   spi_rx_sync_if.slave bus,
   output logic busy,
   output logic frame_err,
   output logic overflow
`ifdef SPI_RX_OVF_CNT_EN
   ,
   output logic [7:0] ovf_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   logic sclk_meta, sclk_s, sclk_d;
   logic cs_meta, cs_s;
   logic mosi_meta, mosi_s;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   logic       fall;
   logic       push;
   logic [7:0] push_data;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          full, pop, wr_en, drop;

   // Stage: pin synchronizers (idle levels on reset so no false edge appears)
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_meta <= 1'b1;
         sclk_s    <= 1'b1;
         sclk_d    <= 1'b1;
         cs_meta   <= 1'b1;
         cs_s      <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         sclk_meta <= bus.sclk;
         sclk_s    <= sclk_meta;
         sclk_d    <= sclk_s;
         cs_meta   <= bus.cs;
         cs_s      <= cs_meta;
         mosi_meta <= bus.mosi;
         mosi_s    <= mosi_meta;
      end
   end

   assign fall      = sclk_d & ~sclk_s;
   // shreg holds the first seven bits; the eighth joins straight from mosi_s on the push
   assign push_data = {shreg, mosi_s};
   assign push      = (state == SHIFT) && !cs_s && fall && (bit_cnt == 3'd7);

   // Stage: frame FSM and byte assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 7'd0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= 3'd0;
               if (!cs_s) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (cs_s) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  bit_cnt   <= 3'd0;
                  frame_err <= (bit_cnt != 3'd0);
               end else if (fall) begin
                  shreg   <= push_data[6:0];
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign full  = (level == LW'(DEPTH));
   assign pop   = (level != '0) && bus.rx_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   // Stage: receive FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

`ifdef SPI_RX_OVF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         ovf_count <= 8'd0;
      else if (drop && ovf_count != 8'hFF)
         ovf_count <= ovf_count + 1'b1;
   end
`endif

   assign bus.rx_valid = (level != '0);
   assign bus.rx_data  = bus.rx_valid ? mem[rd_ptr] : 8'h00;
   assign bus.rx_level = level;
endmodule

// File: tb/tb_spi_rx_sync.sv
// Self-checking bench for spi_rx_sync: directed scenarios plus randomized frames
// checked against a queue-based model of the received byte stream.
module tb_spi_rx_sync;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, frame_err, overflow;
`ifdef SPI_RX_OVF_CNT_EN
   logic [7:0] ovf_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] popped[$];
   int         valid_cycles = 0;
   int         fe_cnt = 0;

   bit             pulse_last = 1'b0;
   logic [LW-1:0]  cap_level;
   logic           cap_ovf;
   logic [7:0]     cap_head;

   spi_rx_sync_if #(.DEPTH(DEPTH)) bus ();

   spi_rx_sync #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .frame_err (frame_err),
      .overflow  (overflow)
`ifdef SPI_RX_OVF_CNT_EN
      ,
      .ovf_count (ovf_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.rx_valid && bus.rx_ready) popped.push_back(bus.rx_data);
      if (bus.rx_valid) valid_cycles <= valid_cycles + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.cs = 1'b1; bus.sclk = 1'b1; bus.mosi = 1'b0; bus.rx_ready = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic cs_low();
      bus.cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      bus.cs = 1'b1;
      tick(6);
   endtask

   // MSB-first, n bits from the top of b; sclk idles high, data taken on the falling edge
   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         bus.mosi = b[7-i];
         tick(4);
         bus.sclk = 1'b0;
         if (pulse_last && i == n - 1) begin
            tick(2);
            bus.rx_ready = 1'b1;
            tick(1);
            bus.rx_ready = 1'b0;
            cap_level = bus.rx_level;
            cap_ovf   = overflow;
            cap_head  = bus.rx_data;
            tick(1);
         end else begin
            tick(4);
         end
         bus.sclk = 1'b1;
      end
      tick(4);
   endtask

   task automatic drain();
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 64 && bus.rx_valid; i++) tick(1);
      checks++;
      if (bus.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout rx_valid=%b required 0", bus.rx_valid);
      end
      bus.rx_ready = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({bus.rx_valid, bus.rx_data, busy, frame_err, overflow} !== 12'h0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b data=%h busy=%b ferr=%b ovf=%b required all 0",
                  bus.rx_valid, bus.rx_data, busy, frame_err, overflow);
      end
      checks++;
      if (bus.rx_level !== '0) begin
         errors++;
         $display("FAIL reset_level got %0d required 0", bus.rx_level);
      end
   endtask

   task automatic test_single_byte();
      int base = popped.size();
      int v0 = valid_cycles;
      int f0 = fe_cnt;
      bus.rx_ready = 1'b1;
      cs_low();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy got %b required 1", busy);
      end
      send_bits(8'h55, 8);
      cs_high();
      bus.rx_ready = 1'b0;
      checks++;
      if (valid_cycles - v0 !== 1) begin
         errors++;
         $display("FAIL single_valid_cycles got %0d required 1", valid_cycles - v0);
      end
      checks++;
      if (popped.size() != base + 1 || popped[base] !== 8'h55) begin
         errors++;
         $display("FAIL single_data count=%0d first=%h required 1 byte 55", popped.size() - base,
                  (popped.size() > base) ? popped[base] : 8'hxx);
      end
      checks++;
      if (fe_cnt - f0 !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_ferr_busy pulses=%0d busy=%b required 0 0", fe_cnt - f0, busy);
      end
   endtask

   task automatic test_back_to_back();
      int base = popped.size();
      cs_low();
      send_bits(8'hA5, 8);
      send_bits(8'h3C, 8);
      cs_high();
      checks++;
      if (bus.rx_level !== LW'(2) || bus.rx_data !== 8'hA5) begin
         errors++;
         $display("FAIL b2b_level_head level=%0d head=%h required 2 a5", bus.rx_level, bus.rx_data);
      end
      drain();
      checks++;
      if (popped.size() != base + 2 || popped[base] !== 8'hA5 || popped[base+1] !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_order count=%0d required a5 3c in order", popped.size() - base);
      end
   endtask

   task automatic test_frame_err();
      int base = popped.size();
      int f0 = fe_cnt;
      cs_low();
      send_bits(8'hFF, 5);
      cs_high();
      checks++;
      if (fe_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_pulse got %0d cycles required 1", fe_cnt - f0);
      end
      checks++;
      if (bus.rx_level !== '0) begin
         errors++;
         $display("FAIL ferr_level got %0d required 0", bus.rx_level);
      end
      cs_low();
      send_bits(8'h81, 8);
      cs_high();
      drain();
      checks++;
      if (popped.size() != base + 1 || popped[base] !== 8'h81 || fe_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_next_byte count=%0d pulses=%0d required 1 byte 81 and 1 pulse",
                  popped.size() - base, fe_cnt - f0);
      end
   endtask

   task automatic test_overflow();
      int base = popped.size();
      apply_reset();
      cs_low();
      for (int i = 1; i <= 5; i++) send_bits(8'(i), 8);
      cs_high();
      checks++;
      if (bus.rx_level !== LW'(4) || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_state level=%0d ovf=%b required 4 1", bus.rx_level, overflow);
      end
`ifdef SPI_RX_OVF_CNT_EN
      checks++;
      if (ovf_count !== 8'd1) begin
         errors++;
         $display("FAIL ovf_count got %0d required 1", ovf_count);
      end
`endif
      drain();
      checks++;
      if (popped.size() != base + 4) begin
         errors++;
         $display("FAIL ovf_pop_count got %0d required 4", popped.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (popped[base+i] !== 8'(i + 1)) begin
               errors++;
               $display("FAIL ovf_pop_%0d got %h required %h", i, popped[base+i], 8'(i + 1));
            end
         end
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky got %b required 1", overflow);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
      int base;
      apply_reset();
      base = popped.size();
      cs_low();
      for (int i = 0; i < 4; i++) send_bits(exp[i], 8);
      pulse_last = 1'b1;
      send_bits(8'h77, 8);
      pulse_last = 1'b0;
      checks++;
      if (cap_level !== LW'(4) || cap_ovf !== 1'b0 || cap_head !== 8'h22) begin
         errors++;
         $display("FAIL fullpp_state level=%0d ovf=%b head=%h required 4 0 22", cap_level, cap_ovf, cap_head);
      end
      cs_high();
      drain();
      checks++;
      if (popped.size() != base + 5) begin
         errors++;
         $display("FAIL fullpp_count got %0d required 5", popped.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (popped[base+i] !== exp[i]) begin
               errors++;
               $display("FAIL fullpp_pop_%0d got %h required %h", i, popped[base+i], exp[i]);
            end
         end
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL fullpp_ovf got %b required 0", overflow);
      end
   endtask

   task automatic test_reset_mid_byte();
      int base;
      int f0 = fe_cnt;
      cs_low();
      send_bits(8'hF0, 4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if ({bus.rx_valid, bus.rx_data, busy, frame_err, overflow} !== 12'h0 || bus.rx_level !== '0) begin
         errors++;
         $display("FAIL midrst_outputs valid=%b data=%h busy=%b ferr=%b ovf=%b level=%0d required all 0",
                  bus.rx_valid, bus.rx_data, busy, frame_err, overflow, bus.rx_level);
      end
      tick(6);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_rearm busy=%b required 1", busy);
      end
      base = popped.size();
      send_bits(8'hC3, 8);
      cs_high();
      drain();
      checks++;
      if (popped.size() != base + 1 || popped[base] !== 8'hC3 || fe_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL midrst_next count=%0d pulses=%0d required 1 byte c3 and 0 pulses",
                  popped.size() - base, fe_cnt - f0);
      end
   endtask

   task automatic test_random();
      logic [7:0] mq[$];
      bit         m_ovf = 1'b0;
      int         m_cnt = 0;
      apply_reset();
      for (int it = 0; it < 10; it++) begin
         int base = popped.size();
         int f0 = fe_cnt;
         int nb = $urandom_range(0, 5);
         int part = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
         cs_low();
         for (int j = 0; j < nb; j++) begin
            logic [7:0] b = 8'($urandom);
            send_bits(b, 8);
            if (mq.size() < DEPTH) mq.push_back(b);
            else begin
               m_ovf = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         if (part != 0) send_bits(8'($urandom), part);
         cs_high();
         checks++;
         if (bus.rx_level !== LW'(mq.size()) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand_%0d_state level=%0d ovf=%b required %0d %b", it, bus.rx_level, overflow,
                     mq.size(), m_ovf);
         end
         checks++;
         if (fe_cnt - f0 !== ((part != 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_%0d_ferr got %0d required %0d", it, fe_cnt - f0, (part != 0) ? 1 : 0);
         end
`ifdef SPI_RX_OVF_CNT_EN
         checks++;
         if (ovf_count !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL rand_%0d_ovfcnt got %0d required %0d", it, ovf_count, m_cnt);
         end
`endif
         drain();
         checks++;
         if (popped.size() != base + mq.size()) begin
            errors++;
            $display("FAIL rand_%0d_count got %0d required %0d", it, popped.size() - base, mq.size());
         end else begin
            for (int k = 0; k < mq.size(); k++) begin
               checks++;
               if (popped[base+k] !== mq[k]) begin
                  errors++;
                  $display("FAIL rand_%0d_byte_%0d got %h required %h", it, k, popped[base+k], mq[k]);
               end
            end
         end
         mq.delete();
      end
   endtask

   initial begin
      bus.cs = 1'b1; bus.sclk = 1'b1; bus.mosi = 1'b0; bus.rx_ready = 1'b0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_frame_err();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_byte();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish required completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/spi_rx_sync.md
SPI_RX_SYNC -- requirements
Module: spi_rx_sync

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 4, receive FIFO entries; power of two, 2..16.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- sclk  input  1  SPI serial clock from the bus master; asynchronous to clk.
- cs  input  1  SPI chip select, active-low; asynchronous.
- mosi  input  1  SPI serial data, MSB first; asynchronous.
- rx_data  output  8  byte at the FIFO head.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts the head byte.
- rx_level  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  a frame is in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse when a partial byte is aborted.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-003 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer on clk; all logic SHALL use only the synchronized copies (sclk_s, cs_s, mosi_s).
REQ-004 A falling edge SHALL be detected when the registered previous sclk_s is 1 and the current sclk_s is 0.
REQ-005 Latency from an sclk pin edge to edge detection SHALL be 3 clk cycles; the sender SHALL hold sclk high and low each for at least 3 clk cycles.
REQ-006 The FSM SHALL have two states:
- IDLE: entered when cs_s=1; bit counter held at 0.
- SHIFT: entered when cs_s=0; returns to IDLE when cs_s=1.
REQ-007 In SHIFT, each detected falling edge SHALL shift mosi_s into bit 0 of an 8-bit shift register (left shift) and increment a 3-bit bit counter.
REQ-008 When the 8th bit is shifted (counter wraps 7->0), the completed byte SHALL be pushed into the FIFO in the same cycle; the FSM SHALL stay in SHIFT for back-to-back bytes.
REQ-009 Falling edges SHALL be ignored in IDLE, including an edge coincident with cs_s going 0.
REQ-010 If cs_s rises with a bit count of 1..7, the partial byte SHALL be discarded, frame_err SHALL pulse for exactly 1 cycle, and the counter SHALL clear.
REQ-011 If cs_s rises with a bit count of 0, frame_err SHALL NOT pulse.
REQ-012 The FIFO SHALL be first-word-fall-through: rx_valid = (rx_level != 0), and rx_data SHALL equal the oldest byte whenever rx_valid=1.
REQ-013 A pop SHALL occur when rx_valid && rx_ready.
REQ-014 A byte pushed into an empty FIFO SHALL appear on rx_data/rx_valid on the next clk cycle.
REQ-015 When the FIFO is full and no pop occurs, a push SHALL be dropped and overflow SHALL set; FIFO contents SHALL be unchanged.
REQ-016 When the FIFO is full and a push and a pop occur in the same cycle, both SHALL take effect, rx_level SHALL remain DEPTH, and overflow SHALL NOT set.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; rx_level SHALL range 0..DEPTH.
REQ-018 busy SHALL be 1 exactly while the FSM is in SHIFT.

Reset
REQ-019 On a clk edge with rst=1: FSM to IDLE; bit counter, shift register, FIFO pointers and rx_level to 0; rx_valid=0, rx_data=0x00, busy=0, frame_err=0, overflow=0; synchronizer flops to 1 for sclk and cs and 0 for mosi.
REQ-020 Reset asserted mid-byte SHALL discard the partial byte with no frame_err pulse.
REQ-021 overflow SHALL be cleared only by rst.

Configuration
REQ-022 Macro SPI_RX_OVF_CNT_EN:
- Defined: the block adds an output ovf_count[7:0] that counts dropped bytes, saturates at 255, and is reset to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- cs low, 8 bits of 0x55, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0x55; frame_err=0.
- Back-to-back 0xA5 then 0x3C in one cs frame, rx_ready=0 -> rx_level=2; pops return 0xA5 then 0x3C.
- cs high after 5 bits of 0xFF -> frame_err pulses once, rx_level=0; the next full byte 0x81 is received intact.
- DEPTH=4, rx_ready=0, bytes 0x01..0x05 -> rx_level=4, overflow=1, pops return 0x01..0x04 (ovf_count=1 with the macro defined).
- FIFO full and rx_ready=1 held while byte 0x77 completes -> no overflow; rx_level stays 4; 0x77 is last out.
- rst asserted after 4 bits -> all outputs at reset values; a following byte 0xC3 is received correctly.
